// File: rtl/transformation_scheduler_pkg.sv
// Shared types and default sizing for the GCN layer transform scheduler.
// Optional build macro used by the top: DOT_PIPE_EN (registers the dot product).
package gcn_pkg;

    localparam int FEATURE_ROWS   = 6;
    localparam int WEIGHT_COLS    = 3;
    localparam int DOT_PROD_WIDTH = 16;
    localparam int MEM_RD_LAT     = 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } sched_state_t;

    // Index width that never collapses to zero bits for a single-entry dimension.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/transformation_scheduler_index_counter.sv
// Row/column walker for the output matrix: row-major, col fastest, saturating at the last element.
module sched_index_counter #(
    parameter int ROWS  = 6,
    parameter int COLS  = 3,
    parameter int ROW_W = 3,
    parameter int COL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_last_col;
    logic             w_last_row;

    assign w_last_col = (r_col == COL_W'(COLS - 1));
    assign w_last_row = (r_row == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv && !(w_last_col && w_last_row)) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_last_col && w_last_row;

endmodule

// File: rtl/transformation_scheduler.sv
// Sequences reads, latency wait and result writes to build FM_WH = FM x WH for one layer.
// Build option: `define DOT_PIPE_EN to register dot_product before it is written (adds one WAIT cycle).
module transformation_scheduler #(
    parameter int FEATURE_ROWS   = gcn_pkg::FEATURE_ROWS,
    parameter int WEIGHT_COLS    = gcn_pkg::WEIGHT_COLS,
    parameter int DOT_PROD_WIDTH = gcn_pkg::DOT_PROD_WIDTH,
    parameter int MEM_RD_LAT     = gcn_pkg::MEM_RD_LAT,
    localparam int ROW_W         = gcn_pkg::clog2_min1(FEATURE_ROWS),
    localparam int COL_W         = gcn_pkg::clog2_min1(WEIGHT_COLS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      read_feature_en,
    output logic [ROW_W-1:0]          read_feature_addr,
    output logic                      read_weight_en,
    output logic [COL_W-1:0]          read_weight_addr,
    input  logic [DOT_PROD_WIDTH-1:0] dot_product,
    output logic                      fm_wh_wr_en,
    output logic [ROW_W-1:0]          fm_wh_wr_row,
    output logic [COL_W-1:0]          fm_wh_wr_col,
    output logic [DOT_PROD_WIDTH-1:0] fm_wh_wr_data
);

    import gcn_pkg::*;

`ifdef DOT_PIPE_EN
    localparam int WAIT_CYC = MEM_RD_LAT + 1;
`else
    localparam int WAIT_CYC = MEM_RD_LAT;
`endif
    localparam int WAIT_W = clog2_min1(WAIT_CYC);

    sched_state_t        r_state, w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
    logic                w_clr, w_adv, w_last;
    logic [ROW_W-1:0]    w_row;
    logic [COL_W-1:0]    w_col;
    logic                r_busy, r_done, r_rd_en, r_wr_en;
    logic [DOT_PROD_WIDTH-1:0] w_dot_src;

    sched_index_counter #(
        .ROWS  (FEATURE_ROWS),
        .COLS  (WEIGHT_COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_adv  (w_adv),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_clr          = 1'b0;
        w_adv          = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = WAIT;
            end
            WAIT: begin
                if (r_wait_cnt == WAIT_W'(WAIT_CYC - 1)) begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = WRITE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            WRITE: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_adv       = 1'b1;
                    w_state_nxt = READ;
                end
            end
            DONE: begin
                // Park indices at zero so the idle address outputs are quiet.
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes are registered off the next state so they line up with the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_busy     <= (w_state_nxt == READ) || (w_state_nxt == WAIT) || (w_state_nxt == WRITE);
            r_done     <= (w_state_nxt == DONE);
            r_rd_en    <= (w_state_nxt == READ);
            r_wr_en    <= (w_state_nxt == WRITE);
        end
    end

`ifdef DOT_PIPE_EN
    logic [DOT_PROD_WIDTH-1:0] r_dot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dot <= '0;
        else        r_dot <= dot_product;
    end

    assign w_dot_src = r_dot;
`else
    assign w_dot_src = dot_product;
`endif

    assign busy              = r_busy;
    assign done              = r_done;
    assign read_feature_en   = r_rd_en;
    assign read_weight_en    = r_rd_en;
    assign read_feature_addr = w_row;
    assign read_weight_addr  = w_col;
    assign fm_wh_wr_en       = r_wr_en;
    assign fm_wh_wr_row      = w_row;
    assign fm_wh_wr_col      = w_col;
    assign fm_wh_wr_data     = r_wr_en ? w_dot_src : '0;

endmodule

// File: tb/tb_transformation_scheduler.sv
// Directed bench for transformation_scheduler on a 2x2 output, memory latency 1.
module tb_transformation_scheduler;

`ifdef DOT_PIPE_EN
    localparam int PER = 4;
`else
    localparam int PER = 3;
`endif
    localparam int NEL    = 4;
    localparam int DONE_K = NEL * PER;
    localparam int NCYC   = DONE_K + 4;

    int n_assert = 0;
    int n_fail   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic        read_feature_en, read_weight_en;
    logic [0:0]  read_feature_addr, read_weight_addr;
    logic [15:0] dot_product;
    logic        fm_wh_wr_en;
    logic [0:0]  fm_wh_wr_row, fm_wh_wr_col;
    logic [15:0] fm_wh_wr_data;
    logic [0:0]  m_row = 1'b0;
    logic [0:0]  m_col = 1'b0;
    logic [24:0] w_all;

    always #5 clk = ~clk;

    transformation_scheduler #(
        .FEATURE_ROWS   (2),
        .WEIGHT_COLS    (2),
        .DOT_PROD_WIDTH (16),
        .MEM_RD_LAT     (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .read_feature_en   (read_feature_en),
        .read_feature_addr (read_feature_addr),
        .read_weight_en    (read_weight_en),
        .read_weight_addr  (read_weight_addr),
        .dot_product       (dot_product),
        .fm_wh_wr_en       (fm_wh_wr_en),
        .fm_wh_wr_row      (fm_wh_wr_row),
        .fm_wh_wr_col      (fm_wh_wr_col),
        .fm_wh_wr_data     (fm_wh_wr_data)
    );

    // One-cycle read latency memory pair feeding a dot product of 10*row+col+1.
    always @(posedge clk) begin
        if (read_feature_en) m_row <= read_feature_addr;
        if (read_weight_en)  m_col <= read_weight_addr;
    end
    assign dot_product = 16'(10 * int'(m_row) + int'(m_col) + 1);

    assign w_all = {busy, done, read_feature_en, read_feature_addr, read_weight_en,
                    read_weight_addr, fm_wh_wr_en, fm_wh_wr_row, fm_wh_wr_col, fm_wh_wr_data};

    int wr_n, wr_r[8], wr_c[8], wr_d[8], wr_k[8];
    int rd_n, rd_fa[8], rd_wa[8], rd_k[8];
    int done_n, done_k;
    logic [24:0] out_at_rst;

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulses start, then logs strobes for ncyc cycles; optional extra start pulse and reset.
    task automatic capture(input int ncyc, input int pulse_k, input int rst_k);
        wr_n = 0; rd_n = 0; done_n = 0; done_k = -1; out_at_rst = '1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                out_at_rst = w_all;
            end
            if (fm_wh_wr_en && wr_n < 8) begin
                wr_r[wr_n] = int'(fm_wh_wr_row);
                wr_c[wr_n] = int'(fm_wh_wr_col);
                wr_d[wr_n] = int'(fm_wh_wr_data);
                wr_k[wr_n] = k;
                wr_n++;
            end
            if (read_feature_en && rd_n < 8) begin
                rd_fa[rd_n] = int'(read_feature_addr);
                rd_wa[rd_n] = int'(read_weight_addr);
                rd_k[rd_n]  = k;
                rd_n++;
            end
            if (done) begin
                done_n++;
                done_k = k;
            end
            start = (k == pulse_k);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        #2;
        n_assert++;
        if (w_all !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", w_all);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_assert++;
            if (w_all !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs[%0d]: got %h expected 0", i, w_all);
            end
        end
    endtask

    task automatic test_pass();
        do_reset();
        capture(NCYC, -1, -1);
        n_assert++;
        if (wr_n !== NEL) begin
            n_fail++;
            $display("FAIL pass_write_count: got %0d expected %0d", wr_n, NEL);
        end
        for (int e = 0; e < NEL && e < wr_n; e++) begin
            n_assert++;
            if (wr_r[e] !== e / 2 || wr_c[e] !== e % 2 || wr_d[e] !== 10 * (e / 2) + (e % 2) + 1
                || wr_k[e] !== PER * e + PER - 1) begin
                n_fail++;
                $display("FAIL pass_write[%0d]: got row %0d col %0d data %0d cyc %0d expected %0d %0d %0d %0d",
                         e, wr_r[e], wr_c[e], wr_d[e], wr_k[e],
                         e / 2, e % 2, 10 * (e / 2) + (e % 2) + 1, PER * e + PER - 1);
            end
        end
        n_assert++;
        if (done_n !== 1 || done_k !== DONE_K) begin
            n_fail++;
            $display("FAIL pass_done: got count %0d cyc %0d expected 1 at %0d", done_n, done_k, DONE_K);
        end
    endtask

    task automatic test_strobes();
        do_reset();
        capture(NCYC, -1, -1);
        n_assert++;
        if (rd_n !== NEL) begin
            n_fail++;
            $display("FAIL rd_count: got %0d expected %0d", rd_n, NEL);
        end
        for (int e = 0; e < NEL && e < rd_n && e < wr_n; e++) begin
            n_assert++;
            if (rd_fa[e] !== wr_r[e] || rd_wa[e] !== wr_c[e] || rd_fa[e] !== e / 2
                || rd_wa[e] !== e % 2 || rd_k[e] !== PER * e) begin
                n_fail++;
                $display("FAIL rd_addr[%0d]: got f %0d w %0d cyc %0d expected %0d %0d %0d",
                         e, rd_fa[e], rd_wa[e], rd_k[e], e / 2, e % 2, PER * e);
            end
        end
    endtask

    task automatic test_start_while_busy();
        do_reset();
        capture(NCYC + 2 * PER, 4, -1);
        n_assert++;
        if (wr_n !== NEL || done_n !== 1 || done_k !== DONE_K) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got writes %0d done %0d at %0d expected %0d 1 %0d",
                     wr_n, done_n, done_k, NEL, DONE_K);
        end
    endtask

    task automatic test_reset_mid_pass();
        do_reset();
        capture(NCYC, -1, 2 * PER + 1);
        n_assert++;
        if (out_at_rst !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0", out_at_rst);
        end
        n_assert++;
        if (wr_n !== 2 || done_n !== 0) begin
            n_fail++;
            $display("FAIL midreset_abort: got writes %0d done %0d expected 2 0", wr_n, done_n);
        end
        rst_n = 1'b1;
        @(negedge clk);
        capture(NCYC, -1, -1);
        n_assert++;
        if (wr_n < 1 || wr_r[0] !== 0 || wr_c[0] !== 0 || wr_d[0] !== 1 || wr_k[0] !== PER - 1) begin
            n_fail++;
            $display("FAIL restart_first_write: got n %0d row %0d col %0d data %0d cyc %0d expected (0,0)=1 at %0d",
                     wr_n, wr_r[0], wr_c[0], wr_d[0], wr_k[0], PER - 1);
        end
        n_assert++;
        if (wr_n !== NEL || done_k !== DONE_K) begin
            n_fail++;
            $display("FAIL restart_pass: got writes %0d done at %0d expected %0d %0d", wr_n, done_k, NEL, DONE_K);
        end
    endtask

    task automatic test_start_held();
        do_reset();
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= DONE_K + 2; k++) begin
            @(negedge clk);
            if (k == DONE_K) begin
                n_assert++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_done_cycle: got done %b busy %b expected 1 0", done, busy);
                end
            end
            if (k == DONE_K + 1) begin
                n_assert++;
                if (done !== 1'b0 || busy !== 1'b0 || read_feature_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_idle_cycle: got done %b busy %b rd %b expected 0 0 0",
                             done, busy, read_feature_en);
                end
            end
            if (k == DONE_K + 2) begin
                n_assert++;
                if (busy !== 1'b1 || read_feature_en !== 1'b1 || read_feature_addr !== 1'b0
                    || read_weight_addr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_reaccept: got busy %b rd %b addr %0d/%0d expected 1 1 0/0",
                             busy, read_feature_en, read_feature_addr, read_weight_addr);
                end
            end
        end
        start = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_strobes();
        test_start_while_busy();
        test_reset_mid_pass();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
